// File: rtl/alu_req_arbiter.sv
// Two-requester front end for a shared registered ALU: arbitrates, drives the ALU for ALU_LAT cycles,
// returns the tagged result. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_req_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic [4:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  input  logic [4:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_select,
  output logic [1:0]       alu_select_calc,
  output logic [1:0]       alu_select_logic,
  input  logic [WIDTH-1:0] alu_final,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [4:0]       op;
  } req_t;

  localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

  state_t     state, state_n;
  logic       last_grant;
  logic       grant;
  logic       hs;
  logic       cur_id;
  logic [2:0] cnt;
  req_t       req0_in, req1_in, sel_req;
  logic [1:0] dec_calc, dec_logic;

  assign req0_in = '{a: req0_a, b: req0_b, cin: req0_cin, op: req0_op};
  assign req1_in = '{a: req1_a, b: req1_b, cin: req1_cin, op: req1_op};

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign hs         = req0_ready | req1_ready;
  assign busy       = (state != IDLE);

  // Sub-selects only pass through for the calculation (000) and logic (001) groups.
  always_comb begin
    sel_req   = grant ? req1_in : req0_in;
    dec_calc  = (sel_req.op[4:2] == 3'b000) ? sel_req.op[1:0] : 2'b00;
    dec_logic = (sel_req.op[4:2] == 3'b001) ? sel_req.op[1:0] : 2'b00;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (hs) state_n = DRIVE;
      DRIVE:   state_n = WAIT;
      WAIT:    if (cnt == 3'd0) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      cur_id           <= 1'b0;
      cnt              <= 3'd0;
      alu_a            <= '0;
      alu_b            <= '0;
      alu_cin          <= 1'b0;
      alu_select       <= 3'd0;
      alu_select_calc  <= 2'd0;
      alu_select_logic <= 2'd0;
      rsp_valid        <= 1'b0;
      rsp_id           <= 1'b0;
      rsp_data         <= '0;
    end else begin
      state <= state_n;
      // ALU inputs are loaded at the handshake edge and left untouched until the next one.
      if (hs) begin
        alu_a            <= sel_req.a;
        alu_b            <= sel_req.b;
        alu_cin          <= sel_req.cin;
        alu_select       <= sel_req.op[4:2];
        alu_select_calc  <= dec_calc;
        alu_select_logic <= dec_logic;
        cur_id           <= grant;
        last_grant       <= grant;
      end
      if (state == DRIVE)
        cnt <= LAT_M1;
      else if (state == WAIT && cnt != 3'd0)
        cnt <= cnt - 3'd1;
      if (state == WAIT && cnt == 3'd0) begin
        rsp_data  <= alu_final;
        rsp_id    <= cur_id;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
